multi_delay_timer: RTL and testbench
====================================

// Module: multi_delay_timer
//
// PURPOSE
//   NCH independent free-running delay timers. Each has a runtime-programmable period
//   and emits a 1-cycle pulse every (period+1) enabled cycles.
//   Period updates go through a shadow register and apply only at the next wrap.
//   Per-channel error and in-window flags are provided for formal and simulation checks.
//   Sits between the control register file and event consumers.
//
// PARAMETERS
//   NCH         4     number of channels (1..16)
//   CBITS       12    counter and period width per channel
//   DEF_PERIOD  2500  reset value of every active and shadow period (< 2**CBITS)
//
// PORTS
//   clk       in   1              clock, all logic on posedge
//   rst       in   1              synchronous, active-high reset
//   en        in   NCH            per-channel count enable
//   ld        in   1              period load strobe
//   ld_ch     in   $clog2(NCH)    channel selected by ld (use 1 bit when NCH==1)
//   ld_val    in   CBITS          new period value
//   err_clr   in   NCH            per-channel sticky error clear
//   sig       out  NCH            wrap pulse, registered
//   err       out  NCH            sticky error, registered
//   flg       out  NCH            1 while cnt < active period, registered
//
// BEHAVIOUR
//   - Reset, per channel:
//       cnt=0, period=shadow=DEF_PERIOD, pend=0, sig=0, err=0, flg=1.
//   - Each cycle with en[i]=1:
//       - If cnt >= period: next cnt=0, sig[i]=1 for exactly one cycle.
//         If pend is set, period<=shadow and pend<=0 in that same cycle.
//       - Else: cnt<=cnt+1 (never wraps at 2**CBITS), sig[i]=0.
//   - en[i]=0: cnt and period hold, sig[i]=0. Pulses always stay 1 cycle wide.
//   - flg[i]: registered as (next cnt < next period).
//   - Load (ld=1):
//       - ld_val!=0: shadow[ld_ch]<=ld_val, pend<=1. A second load before the wrap
//         overwrites shadow (last write wins).
//       - ld_val==0: the load is rejected. Shadow and pend are unchanged; err[ld_ch]<=1.
//       - ld_ch >= NCH: the load is ignored, with no error.
//   - err[i] also sets if cnt > period is ever observed. This is an invariant
//     violation and must be unreachable.
//   - err_clr[i] clears err[i]. A set condition in the same cycle wins over the clear.
//   - Channels are fully independent. A load to channel j never perturbs channel i.
//   - rst asserted mid-count: all state returns to reset values on the next edge,
//     and any pending shadow is discarded.
//   - A load in the same cycle as a wrap: the wrap uses the old shadow/pend state.
//     The new value becomes pending and applies at the following wrap.
//   - Latency: sig[i] rises on the edge after the cycle in which cnt==period with en=1.
//   - Width rule: all compares are unsigned CBITS. period >= 1 always holds after reset.
//
// CONFIGURATION
//   TIMER_ONESHOT_EN (defined):
//     - Adds port oneshot (in, NCH) and port done (out, NCH; reset 0).
//     - With oneshot[i]=1, channel i halts after its first sig pulse: cnt holds at 0
//       and done[i]=1, regardless of en[i].
//     - done[i] clears, and counting resumes, on a load to channel i or on rst.
//   TIMER_ONESHOT_EN (undefined):
//     - Neither port exists. All channels are free-running only.
//
// TESTING
//   1. Reset defaults: rst 1 cycle, en=all 1 -> first sig on every channel 2501
//      cycles after rst deasserts, then every 2501 cycles; err=0 throughout.
//   2. Deferred reload: ch1 period 2500, load ld_val=10 at cnt=100 ->
//      - the current interval still ends at 2500;
//      - subsequent sig pulses on ch1 are spaced 11 cycles apart;
//      - ch0, ch2 and ch3 are unaffected.
//   3. Zero load: ld=1, ld_ch=2, ld_val=0 -> err[2]=1 next cycle, period unchanged.
//      err_clr[2]=1 -> err[2]=0.
//   4. Enable gating: period 5, en[0] toggling 1/0 each cycle -> sig[0] every 12 cycles.
//      flg[0]=0 only in the cycle after each wrap-cycle count of 5.
//   5. Reset mid-operation: pending load on ch3, rst at cnt=1234 ->
//      - cnt=0, pend cleared, period=2500;
//      - next sig on ch3 2501 cycles later.
//   6. (TIMER_ONESHOT_EN) oneshot[0]=1, period 3 -> exactly one sig[0] after 4 cycles,
//      done[0]=1 and no further pulses. Load 7 -> done[0]=0 and one pulse after 8 cycles.

Source files
------------

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: NCH independent free-running delay timers.
// Each channel counts enabled cycles up to its active period, emits a
// one-cycle wrap pulse and restarts. New periods land in a shadow register
// and take effect at the next wrap. Sticky per-channel error flags cover
// rejected zero loads and the (unreachable) cnt > period condition.
// Optional feature macro: TIMER_ONESHOT_EN adds oneshot/done ports.
module multi_delay_timer #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CBITS      = 12,
  parameter int unsigned DEF_PERIOD = 2500,
  localparam int unsigned LCW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             ld,
  input  logic [LCW-1:0]   ld_ch,
  input  logic [CBITS-1:0] ld_val,
  input  logic [NCH-1:0]   err_clr,
`ifdef TIMER_ONESHOT_EN
  input  logic [NCH-1:0]   oneshot,
  output logic [NCH-1:0]   done,
`endif
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   err,
  output logic [NCH-1:0]   flg
);

  localparam logic [CBITS-1:0] DEF_P = CBITS'(DEF_PERIOD);

  logic [CBITS-1:0] cnt    [NCH];
  logic [CBITS-1:0] period [NCH];
  logic [CBITS-1:0] shadow [NCH];
  logic [NCH-1:0]   pend;

  logic [CBITS-1:0] cnt_n  [NCH];
  logic [CBITS-1:0] per_n  [NCH];
  logic [CBITS-1:0] shd_n  [NCH];
  logic [NCH-1:0]   pend_n;
  logic [NCH-1:0]   sig_n;
  logic [NCH-1:0]   err_n;
  logic [NCH-1:0]   flg_n;
  logic [NCH-1:0]   ld_hit;
`ifdef TIMER_ONESHOT_EN
  logic [NCH-1:0]   done_n;
`endif

  // Decode the load strobe into a per-channel hit; out-of-range channels are dropped.
  always_comb begin
    ld_hit = '0;
    if (ld && (32'(ld_ch) < NCH)) ld_hit[ld_ch] = 1'b1;
  end

  // Per-channel next state: count/wrap, deferred period swap, loads and error flags.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_n[i]  = cnt[i];
      per_n[i]  = period[i];
      shd_n[i]  = shadow[i];
      pend_n[i] = pend[i];
      sig_n[i]  = 1'b0;
      err_n[i]  = err[i];
`ifdef TIMER_ONESHOT_EN
      done_n[i] = done[i];
`endif
      // Clear first so that any set condition below overrides it.
      if (err_clr[i]) err_n[i] = 1'b0;
      if (cnt[i] > period[i]) err_n[i] = 1'b1;

`ifdef TIMER_ONESHOT_EN
      if (!done[i] && en[i]) begin
`else
      if (en[i]) begin
`endif
        if (cnt[i] >= period[i]) begin
          cnt_n[i] = '0;
          sig_n[i] = 1'b1;
          if (pend[i]) begin
            per_n[i]  = shadow[i];
            pend_n[i] = 1'b0;
          end
`ifdef TIMER_ONESHOT_EN
          if (oneshot[i]) done_n[i] = 1'b1;
`endif
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end

      // The wrap above already consumed the old shadow, so a same-cycle
      // load simply becomes the next pending value.
      if (ld_hit[i]) begin
        if (ld_val == '0) begin
          err_n[i] = 1'b1;
        end else begin
          shd_n[i]  = ld_val;
          pend_n[i] = 1'b1;
`ifdef TIMER_ONESHOT_EN
          // A halted channel has no interval in flight: apply the period at once.
          if (done[i]) begin
            per_n[i]  = ld_val;
            pend_n[i] = 1'b0;
            done_n[i] = 1'b0;
          end
`endif
        end
      end

      flg_n[i] = (cnt_n[i] < per_n[i]);
    end
  end

  // Register all channel state; reset discards any pending shadow value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        period[i] <= DEF_P;
        shadow[i] <= DEF_P;
      end
      pend <= '0;
      sig  <= '0;
      err  <= '0;
      flg  <= '1;
`ifdef TIMER_ONESHOT_EN
      done <= '0;
`endif
    end else begin
      cnt    <= cnt_n;
      period <= per_n;
      shadow <= shd_n;
      pend   <= pend_n;
      sig    <= sig_n;
      err    <= err_n;
      flg    <= flg_n;
`ifdef TIMER_ONESHOT_EN
      done   <= done_n;
`endif
    end
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// tb_multi_delay_timer: scoreboard bench for multi_delay_timer (NCH=4, CBITS=12,
// DEF_PERIOD=2500). Expected wrap pulses are queued with their cycle number when
// stimulus is applied; a negedge monitor matches every sig pulse against the queue.
module tb_multi_delay_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = 4'hF;
  logic        ld = 1'b0;
  logic [1:0]  ld_ch = 2'd0;
  logic [11:0] ld_val = 12'd0;
  logic [3:0]  err_clr = 4'h0;
  logic [3:0]  sig;
  logic [3:0]  err;
  logic [3:0]  flg;
`ifdef TIMER_ONESHOT_EN
  logic [3:0]  oneshot = 4'h0;
  logic [3:0]  done;
`endif

  multi_delay_timer #(
    .NCH(4),
    .CBITS(12),
    .DEF_PERIOD(2500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .ld(ld),
    .ld_ch(ld_ch),
    .ld_val(ld_val),
    .err_clr(err_clr),
`ifdef TIMER_ONESHOT_EN
    .oneshot(oneshot),
    .done(done),
`endif
    .sig(sig),
    .err(err),
    .flg(flg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mon_hit;
  logic mon_en = 1'b0;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Match every observed pulse to the scoreboard; flag unexpected and missing pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        if (sig[c]) begin
          mon_hit = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k].ch == c && exp_q[k].cyc == cyc) mon_hit = k;
          checks++;
          if (mon_hit < 0) begin
            failures++;
            $display("FAIL sig_unexpected ch=%0d cyc=%0d got=1 want=0", c, cyc);
          end else begin
            exp_q.delete(mon_hit);
          end
        end
      end
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
        if (exp_q[k].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL sig_missing ch=%0d cyc=%0d got=0 want=1", exp_q[k].ch, exp_q[k].cyc);
          exp_q.delete(k);
        end
      end
    end
  end

  function automatic void expect_pulse(input int ch, input int t);
    exp_t e;
    e.ch  = ch;
    e.cyc = t;
    exp_q.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-cycle reset; returns the edge index at which reset was applied (cnt=0 there).
  task automatic do_reset(output int t0);
    @(negedge clk);
    mon_en  = 1'b0;
    rst     = 1'b1;
    ld      = 1'b0;
    err_clr = 4'h0;
    en      = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    t0 = cyc;
    mon_en = 1'b1;
  endtask

  task automatic load(input logic [1:0] ch, input logic [11:0] val);
    ld = 1'b1; ld_ch = ch; ld_val = val;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic test_reset_defaults();
    int t0;
    do_reset(t0);
    checks++;
    if (sig !== 4'h0) begin failures++; $display("FAIL reset_sig got=%h want=%h", sig, 4'h0); end
    checks++;
    if (err !== 4'h0) begin failures++; $display("FAIL reset_err got=%h want=%h", err, 4'h0); end
    checks++;
    if (flg !== 4'hF) begin failures++; $display("FAIL reset_flg got=%h want=%h", flg, 4'hF); end
    for (int k = 1; k <= 3; k++)
      for (int c = 0; c < 4; c++) expect_pulse(c, t0 + 2501 * k);
    wait_until(t0 + 2500);
    checks++;
    if (flg !== 4'h0) begin failures++; $display("FAIL dflt_flg_at_period got=%h want=%h", flg, 4'h0); end
    wait_until(t0 + 2501);
    checks++;
    if (flg !== 4'hF) begin failures++; $display("FAIL dflt_flg_after_wrap got=%h want=%h", flg, 4'hF); end
    wait_until(t0 + 3 * 2501 + 3);
    checks++;
    if (err !== 4'h0) begin failures++; $display("FAIL dflt_err got=%h want=%h", err, 4'h0); end
    mon_en = 1'b0;
  endtask

  task automatic test_deferred_reload();
    int t0;
    do_reset(t0);
    for (int c = 0; c < 4; c++) expect_pulse(c, t0 + 2501);
    for (int k = 1; k <= 20; k++) expect_pulse(1, t0 + 2501 + 11 * k);
    wait_until(t0 + 100);
    load(2'd1, 12'd10);
    wait_until(t0 + 2511);
    checks++;
    if (flg !== 4'b1101) begin failures++; $display("FAIL reload_flg got=%b want=%b", flg, 4'b1101); end
    wait_until(t0 + 2501 + 220 + 3);
    checks++;
    if (err !== 4'h0) begin failures++; $display("FAIL reload_err got=%h want=%h", err, 4'h0); end
    mon_en = 1'b0;
  endtask

  task automatic test_zero_load();
    int t0;
    do_reset(t0);
    for (int c = 0; c < 4; c++) expect_pulse(c, t0 + 2501);
    wait_until(t0 + 5);
    ld = 1'b1; ld_ch = 2'd2; ld_val = 12'd0;
    @(negedge clk);
    checks++;
    if (err !== 4'b0100) begin failures++; $display("FAIL zero_err_set got=%b want=%b", err, 4'b0100); end
    err_clr = 4'b0100;
    @(negedge clk);
    ld = 1'b0;
    checks++;
    if (err !== 4'b0100) begin failures++; $display("FAIL zero_set_beats_clr got=%b want=%b", err, 4'b0100); end
    @(negedge clk);
    err_clr = 4'h0;
    checks++;
    if (err !== 4'b0000) begin failures++; $display("FAIL zero_err_clr got=%b want=%b", err, 4'b0000); end
    wait_until(t0 + 2515);
    checks++;
    if (err !== 4'h0) begin failures++; $display("FAIL zero_err_final got=%h want=%h", err, 4'h0); end
    mon_en = 1'b0;
  endtask

  task automatic test_enable_gating();
    int t0;
    int o;
    int c0;
    logic f_exp;
    do_reset(t0);
    load(2'd0, 12'd5);
    for (int c = 0; c < 4; c++) expect_pulse(c, t0 + 2501);
    for (int k = 1; k <= 4; k++) expect_pulse(0, t0 + 2500 + 12 * k);
    wait_until(t0 + 2501);
    for (int off = 2501; off <= 2552; off++) begin
      o = off - 2501;
      if (o > 0) begin
        c0 = ((o + 1) / 2) % 6;
        f_exp = (c0 != 5);
        checks++;
        if (flg[0] !== f_exp) begin
          failures++;
          $display("FAIL gate_flg0 cyc_off=%0d got=%b want=%b", off, flg[0], f_exp);
        end
      end
      en[0] = (o % 2 == 0);
      @(negedge clk);
    end
    en[0] = 1'b1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t0;
    int t1;
    do_reset(t0);
    load(2'd3, 12'd10);
    wait_until(t0 + 1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t1 = cyc;
    checks++;
    if (flg !== 4'hF) begin failures++; $display("FAIL midrst_flg got=%h want=%h", flg, 4'hF); end
    checks++;
    if (sig !== 4'h0) begin failures++; $display("FAIL midrst_sig got=%h want=%h", sig, 4'h0); end
    for (int c = 0; c < 4; c++) expect_pulse(c, t1 + 2501);
    wait_until(t1 + 2501 + 15);
    checks++;
    if (err !== 4'h0) begin failures++; $display("FAIL midrst_err got=%h want=%h", err, 4'h0); end
    mon_en = 1'b0;
  endtask

`ifdef TIMER_ONESHOT_EN
  task automatic test_oneshot();
    int t0;
    oneshot = 4'b0001;
    do_reset(t0);
    for (int c = 0; c < 4; c++) expect_pulse(c, t0 + 2501);
    wait_until(t0 + 2501);
    checks++;
    if (done !== 4'b0001) begin failures++; $display("FAIL os_done_first got=%b want=%b", done, 4'b0001); end
    wait_until(t0 + 2505);
    expect_pulse(0, t0 + 2510);
    load(2'd0, 12'd3);
    checks++;
    if (done !== 4'b0000) begin failures++; $display("FAIL os_done_clr3 got=%b want=%b", done, 4'b0000); end
    wait_until(t0 + 2510);
    checks++;
    if (done !== 4'b0001) begin failures++; $display("FAIL os_done_p3 got=%b want=%b", done, 4'b0001); end
    wait_until(t0 + 2515);
    expect_pulse(0, t0 + 2524);
    load(2'd0, 12'd7);
    checks++;
    if (done !== 4'b0000) begin failures++; $display("FAIL os_done_clr7 got=%b want=%b", done, 4'b0000); end
    wait_until(t0 + 2540);
    checks++;
    if (done !== 4'b0001) begin failures++; $display("FAIL os_done_p7 got=%b want=%b", done, 4'b0001); end
    mon_en = 1'b0;
    oneshot = 4'h0;
  endtask
`endif

  initial begin
    test_reset_defaults();
    test_deferred_reload();
    test_zero_load();
    test_enable_gating();
    test_reset_mid();
`ifdef TIMER_ONESHOT_EN
    test_oneshot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
